dkong_sound_cmd: RTL
====================

DKONG_SOUND_CMD -- requirements
Module: dkong_sound_cmd

Interface
REQ-001 SHALL have parameter HOLD_CLKS, default 4096: minimum clocks a trigger output holds a level after any change (1..4095 legal; 4096 = counter full range).
REQ-002 SHALL have port W_CLK_24576M  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port W_RESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port I_D  in  8  main-CPU write data; bit 0 is the addressable-latch data bit.
REQ-005 SHALL have port I_A  in  3  addressable-latch bit select.
REQ-006 SHALL have ports I_3D_WE, I_6H_WE, I_5H_WE, I_4H_WE  in  1 each  level write strobes, multi-clock, decoded by the main CPU.
REQ-007 SHALL have port I_SACK  in  1  sound-CPU acknowledge from the soundboard, asynchronous.
REQ-008 SHALL have port W_3D_Q  out  5  sound data latch.
REQ-009 SHALL have port W_6H_Q  out  7  sound trigger latch.
REQ-010 SHALL have port W_5H_Q0  out  1  sound-CPU interrupt/trigger bit.
REQ-011 SHALL have port W_4H_Q  out  2  DKJR extra control bits.
REQ-012 SHALL have port O_SACK_RD  out  1  synchronized I_SACK for main-CPU readback.
REQ-013 SHALL have port O_BUSY  out  1  high while any trigger channel has a running hold counter or a pending value.

Function
REQ-014 SHALL register each WE strobe and detect a write only on its rising edge (strobe=1, previous=0); a strobe held high is exactly one write.
REQ-015 SHALL update a write's target on the clock edge where the rising edge is detected (latency 1 clock from strobe first sampled high).
REQ-016 SHALL load W_3D_Q <= I_D[4:0] on a 3D write, immediately, with no hold logic.
REQ-017 SHALL give 6H, 5H and 4H 74LS259 addressable-latch semantics: the write sets bit I_A to I_D[0]; other bits unchanged.
REQ-018 SHALL ignore 6H writes with I_A=7, 5H writes with I_A!=0, and 4H writes with I_A>1; no output, counter or pending change.
REQ-019 SHALL apply W_4H_Q writes immediately, with no hold logic.
REQ-020 SHALL give each of the 8 trigger channels (W_6H_Q[6:0], W_5H_Q0) an output bit, a 12-bit hold counter, a pending-valid flag and a pending value.
REQ-021 SHALL, on a write to an idle channel (counter 0, no pending) whose value differs from the output: update the output and load the counter with HOLD_CLKS-1.
REQ-022 SHALL treat a write of the same value to an idle channel as a no-op; the counter is not loaded.
REQ-023 SHALL, on a write while the channel's counter is nonzero: store the value as pending and set pending-valid; a later write overwrites the pending value (last write wins).
REQ-024 SHALL decrement a nonzero counter by 1 per clock.
REQ-025 SHALL, in the clock where the counter is 1 and pending is valid: clear pending-valid; if the pending value differs from the output, drive it on the next edge and reload the counter with HOLD_CLKS-1, otherwise let the counter reach 0.
REQ-026 SHALL, when a write and counter expiry coincide on a channel, take the new write value as the pending value before the expiry rule is applied.
REQ-027 SHALL form O_SACK_RD from I_SACK through a 2-flop synchronizer (latency 2 clocks).
REQ-028 SHALL drive O_BUSY as the registered OR of (counter!=0 | pending-valid) over all 8 channels.

Reset
REQ-029 SHALL, on W_RESETn low, asynchronously clear all outputs to 0, all counters to 0, all pending flags to 0, the strobe history to 0 and the synchronizer to 0.
REQ-030 SHALL treat a strobe already high at reset release as not a write until it falls and rises again.
REQ-031 SHALL, when reset asserts mid-hold, discard any pending value with no deferred output.

Verification
REQ-032 SHALL be verified for a 3D write with I_D=8'hF5 -> W_3D_Q=5'h15 one clock after strobe first sampled; strobe held 10 clocks -> a single write.
REQ-033 SHALL be verified for a 6H write with I_A=2, D0=1, then I_A=5, D0=1 -> W_6H_Q=7'h24; a 6H write with I_A=7 -> no change and O_BUSY unchanged.
REQ-034 SHALL be verified with HOLD_CLKS=16: 6H bit0 set, cleared 3 clocks later -> bit0 stays 1 for exactly 16 clocks, then 0 for 16 clocks; O_BUSY falls after the second hold.
REQ-035 SHALL be verified with HOLD_CLKS=16: 5H bit set, then writes 0 and 1 within the hold -> W_5H_Q0 never drops, the counter is not reloaded, and O_BUSY falls 16 clocks after the first write.
REQ-036 SHALL be verified by pulsing I_SACK 0->1 -> O_SACK_RD rises 2 clocks later; reset asserted mid-hold with pending -> all outputs 0 at once and no later transition.

Source files
------------

// File: rtl/dkong_sound_cmd.sv
// Main-CPU sound command latches (3D, 6H, 5H, 4H) with per-channel
// trigger hold timing, SACK synchronizer and busy flag.
//
// Ports:
//   W_CLK_24576M   sole clock
//   W_RESETn       async active-low reset
//   I_D, I_A       CPU write data / latch bit select
//   I_*_WE         level write strobes, one write per rising edge
//   I_SACK         async sound-CPU acknowledge
//   W_3D_Q         sound data latch
//   W_6H_Q         sound trigger latch
//   W_5H_Q0        sound-CPU interrupt bit
//   W_4H_Q         DKJR extra control bits
//   O_SACK_RD      synchronized I_SACK
//   O_BUSY         a trigger channel is holding or has a pending value
module dkong_sound_cmd #(
  parameter int HOLD_CLKS = 4096
) (
  input  logic       W_CLK_24576M,
  input  logic       W_RESETn,
  input  logic [7:0] I_D,
  input  logic [2:0] I_A,
  input  logic       I_3D_WE,
  input  logic       I_6H_WE,
  input  logic       I_5H_WE,
  input  logic       I_4H_WE,
  input  logic       I_SACK,
  output logic [4:0] W_3D_Q,
  output logic [6:0] W_6H_Q,
  output logic       W_5H_Q0,
  output logic [1:0] W_4H_Q,
  output logic       O_SACK_RD,
  output logic       O_BUSY
);

  localparam logic [11:0] RELOAD = 12'(HOLD_CLKS - 1);

  logic [3:0]  we;
  logic [3:0]  lo_q;
  logic [3:0]  wr;
  logic [4:0]  d3_q, d3_d;
  logic [1:0]  h4_q, h4_d;
  logic [7:0]  chw;
  logic [7:0]  out_q, out_d;
  logic [7:0]  pv_q, pv_d;
  logic [7:0]  pval_q, pval_d;
  logic [7:0]  app_q, app_d;
  logic [7:0]  cnz;
  logic [11:0] cnt_q [8];
  logic [11:0] cnt_d [8];
  logic [1:0]  sack_q;
  logic        busy_q;

  assign we = {I_4H_WE, I_5H_WE, I_6H_WE, I_3D_WE};
  // lo_q resets to 0, so a strobe high at reset release must
  // first be seen low before it can count as a write.
  assign wr = we & lo_q;

  always_comb begin
    d3_d = d3_q;
    h4_d = h4_q;
    chw  = '0;
    if (wr[0]) d3_d = I_D[4:0];
    if (wr[1] && I_A != 3'd7) chw[I_A] = 1'b1;
    if (wr[2] && I_A == 3'd0) chw[7] = 1'b1;
    if (wr[3] && I_A <= 3'd1) h4_d[I_A[0]] = I_D[0];
  end

  always_comb begin
    logic v;
    logic epv;
    out_d  = out_q;
    pv_d   = pv_q;
    pval_d = pval_q;
    app_d  = app_q;
    cnz    = '0;
    v      = 1'b0;
    epv    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      cnz[i]   = cnt_q[i] != 12'd0;
      v   = chw[i] ? I_D[0] : pval_q[i];
      epv = pv_q[i] | chw[i];
      if (!cnz[i]) begin
        // Idle, or applying a pending value one edge after expiry.
        if (chw[i] || app_q[i]) begin
          app_d[i] = 1'b0;
          if (v != out_q[i]) begin
            out_d[i] = v;
            cnt_d[i] = RELOAD;
          end
        end
      end else begin
        pval_d[i] = v;
        if (cnt_q[i] == 12'd1 && epv) begin
          pv_d[i]  = 1'b0;
          cnt_d[i] = 12'd0;
          app_d[i] = v != out_q[i];
        end else begin
          pv_d[i]  = epv;
          cnt_d[i] = cnt_q[i] - 12'd1;
        end
      end
    end
  end

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      lo_q   <= '0;
      d3_q   <= '0;
      h4_q   <= '0;
      out_q  <= '0;
      pv_q   <= '0;
      pval_q <= '0;
      app_q  <= '0;
      sack_q <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      lo_q   <= ~we;
      d3_q   <= d3_d;
      h4_q   <= h4_d;
      out_q  <= out_d;
      pv_q   <= pv_d;
      pval_q <= pval_d;
      app_q  <= app_d;
      sack_q <= {sack_q[0], I_SACK};
      busy_q <= |(cnz | pv_q | app_q);
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign W_3D_Q    = d3_q;
  assign W_6H_Q    = out_q[6:0];
  assign W_5H_Q0   = out_q[7];
  assign W_4H_Q    = h4_q;
  assign O_SACK_RD = sack_q[1];
  assign O_BUSY    = busy_q;

endmodule
